// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: filters the PS/2 clock, deserialises 11-bit frames and folds E0/F0 prefixes into flags.
// One-cycle kb_interrupt / frame_err strobe the cycle after the stop-bit sample; no backpressure, events are never queued.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_rcv,
  input  logic       ps2clk_ext,
  input  logic       ps2data_ext,
  output logic       kb_interrupt,
  output logic [7:0] scancode,
  output logic       released,
  output logic       extended,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic          r_clk_s1, r_clk_s2;
  logic          r_dat_s1, r_dat_s2;
  logic          r_filt;
  logic [FW-1:0] r_fcnt;
  logic          r_fall;

  state_t        r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tcnt;
  logic          r_ext_pend, r_rel_pend;
  logic          r_kb_int, r_ferr;
  logic [7:0]    r_scancode;
  logic          r_released, r_extended;

  logic          w_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2clk_ext;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2data_ext;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // r_fcnt counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
      r_fall <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (r_clk_s2 == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_filt <= r_clk_s2;
        r_fcnt <= '0;
        r_fall <= ~r_clk_s2;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_valid = r_dat_s2 & (^{r_shift, r_par});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_bitcnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_par      <= 1'b0;
      r_tcnt     <= '0;
      r_ext_pend <= 1'b0;
      r_rel_pend <= 1'b0;
      r_kb_int   <= 1'b0;
      r_ferr     <= 1'b0;
      r_scancode <= 8'h00;
      r_released <= 1'b0;
      r_extended <= 1'b0;
    end else begin
      r_kb_int <= 1'b0;
      r_ferr   <= 1'b0;
      if (!enable_rcv) begin
        r_state    <= IDLE;
        r_tcnt     <= '0;
        r_ext_pend <= 1'b0;
        r_rel_pend <= 1'b0;
      end else if (r_fall) begin
        r_tcnt <= '0;
        case (r_state)
          IDLE: begin
            if (!r_dat_s2) begin
              r_state  <= DATA;
              r_bitcnt <= 3'd0;
            end
          end
          DATA: begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
            if (r_bitcnt == 3'd7) r_state <= PARITY;
            else                  r_bitcnt <= r_bitcnt + 3'd1;
          end
          PARITY: begin
            r_par   <= r_dat_s2;
            r_state <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (!w_valid) begin
              r_ferr     <= 1'b1;
              r_ext_pend <= 1'b0;
              r_rel_pend <= 1'b0;
            end else if (r_shift == 8'hE0) begin
              r_ext_pend <= 1'b1;
            end else if (r_shift == 8'hF0) begin
              r_rel_pend <= 1'b1;
            end else begin
              r_kb_int   <= 1'b1;
              r_scancode <= r_shift;
              r_released <= r_rel_pend;
              r_extended <= r_ext_pend;
              r_ext_pend <= 1'b0;
              r_rel_pend <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_state == IDLE) begin
        r_tcnt <= '0;
      end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        // A stalled partial frame is dropped along with any prefix it followed.
        r_state    <= IDLE;
        r_tcnt     <= '0;
        r_ext_pend <= 1'b0;
        r_rel_pend <= 1'b0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  assign kb_interrupt = r_kb_int;
  assign frame_err    = r_ferr;
  assign scancode     = r_scancode;
  assign released     = r_released;
  assign extended     = r_extended;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: a bit-banged PS/2 device, a scoreboard of expected events and a strobe monitor.
module tb_ps2_scancode_rx;

  localparam int H  = 40;
  localparam int TO = 2000;

  logic       clk = 1'b0;
  logic       rst_n, enable_rcv, ps2clk_ext, ps2data_ext;
  logic       kb_interrupt, released, extended, frame_err;
  logic [7:0] scancode;

  always #5 clk = ~clk;

  ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_rcv   (enable_rcv),
    .ps2clk_ext   (ps2clk_ext),
    .ps2data_ext  (ps2data_ext),
    .kb_interrupt (kb_interrupt),
    .scancode     (scancode),
    .released     (released),
    .extended     (extended),
    .frame_err    (frame_err)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  rx_q[$];
  int   tests = 0;
  int   fails = 0;
  int   rd_idx = 0;
  int   both_cnt = 0;
  int   long_cnt = 0;
  logic prev_stb = 1'b0;

  logic [7:0] m_code;
  logic       m_rel, m_ext, m_ep, m_rp;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (kb_interrupt || frame_err) rx_q.push_back({frame_err, scancode, released, extended});
      if (kb_interrupt && frame_err) both_cnt++;
      if (prev_stb && (kb_interrupt || frame_err)) long_cnt++;
    end
    prev_stb = kb_interrupt | frame_err;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad);
    mk_frame = {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      ps2data_ext = f[i];
      if (i == glitch_at) begin
        wait_cyc(10);
        ps2clk_ext = 1'b0;
        wait_cyc(3);
        ps2clk_ext = 1'b1;
        wait_cyc(H - 13);
      end else begin
        wait_cyc(H);
      end
      ps2clk_ext = 1'b0;
      wait_cyc(H);
      ps2clk_ext = 1'b1;
    end
    ps2data_ext = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad, input int glitch_at);
    send_bits(mk_frame(b, bad), 11, glitch_at);
    if (bad) begin
      exp_q.push_back({1'b1, m_code, m_rel, m_ext});
      m_ep = 1'b0;
      m_rp = 1'b0;
    end else if (b == 8'hE0) begin
      m_ep = 1'b1;
    end else if (b == 8'hF0) begin
      m_rp = 1'b1;
    end else begin
      m_code = b;
      m_rel  = m_rp;
      m_ext  = m_ep;
      exp_q.push_back({1'b0, m_code, m_rel, m_ext});
      m_ep = 1'b0;
      m_rp = 1'b0;
    end
    wait_cyc(60);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_step(input string tag);
    tests++;
    assert (rx_q.size() === exp_q.size()) else begin
      fails++;
      $error("FAIL %s event_count observed=%0d expected=%0d", tag, rx_q.size(), exp_q.size());
    end
    for (int i = rd_idx; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) begin
        tests++;
        assert (rx_q[i] === exp_q[i]) else begin
          fails++;
          $error("FAIL %s ev%0d observed err=%0b code=%h rel=%0b ext=%0b expected err=%0b code=%h rel=%0b ext=%0b",
                 tag, i, rx_q[i].err, rx_q[i].code, rx_q[i].rel, rx_q[i].ext,
                 exp_q[i].err, exp_q[i].code, exp_q[i].rel, exp_q[i].ext);
        end
      end
    end
    rd_idx = exp_q.size();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_kb_int"},   {7'd0, kb_interrupt}, 8'h00);
    chk({tag, "_scancode"}, scancode,             8'h00);
    chk({tag, "_released"}, {7'd0, released},     8'h00);
    chk({tag, "_extended"}, {7'd0, extended},     8'h00);
    chk({tag, "_frame_err"},{7'd0, frame_err},    8'h00);
  endtask

  initial begin
    m_code = 8'h00; m_rel = 1'b0; m_ext = 1'b0; m_ep = 1'b0; m_rp = 1'b0;
    rst_n = 1'b0; enable_rcv = 1'b1; ps2clk_ext = 1'b1; ps2data_ext = 1'b1;
    wait_cyc(5);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cyc(20);

    send_byte(8'h70, 1'b0, -1);
    check_step("t1_70");
    chk("t1_scancode_live", scancode, 8'h70);

    send_byte(8'hE0, 1'b0, -1);
    send_byte(8'hF0, 1'b0, -1);
    check_step("t2_prefix_no_strobe");
    send_byte(8'h5A, 1'b0, -1);
    check_step("t2_E0F05A");
    send_byte(8'hE0, 1'b0, -1);
    send_byte(8'h5A, 1'b0, -1);
    check_step("t2_E05A");

    send_byte(8'hE0, 1'b0, -1);
    send_byte(8'h69, 1'b1, -1);
    check_step("t3_bad_parity");
    chk("t3_scancode_hold", scancode, 8'h5A);
    send_byte(8'hF0, 1'b0, -1);
    send_byte(8'h69, 1'b0, -1);
    check_step("t3_F069");

    send_bits(mk_frame(8'h72, 1'b0), 5, -1);
    wait_cyc(TO + 500);
    check_step("t4_partial");
    send_byte(8'h72, 1'b0, -1);
    check_step("t4_72");
    chk("t4_scancode_live", scancode, 8'h72);

    send_byte(8'h7A, 1'b0, 4);
    check_step("t5_glitch_7A");
    send_byte(8'hF0, 1'b0, -1);
    send_bits(mk_frame(8'h33, 1'b0), 6, -1);
    enable_rcv = 1'b0;
    m_rp = 1'b0;
    m_ep = 1'b0;
    wait_cyc(50);
    enable_rcv = 1'b1;
    wait_cyc(50);
    check_step("t5_disabled");
    send_byte(8'h6B, 1'b0, -1);
    check_step("t5_6B_after_enable");

    send_byte(8'hE0, 1'b0, -1);
    send_bits(mk_frame(8'h44, 1'b0), 5, -1);
    rst_n = 1'b0;
    wait_cyc(3);
    chk_reset_outputs("t6_in_reset");
    m_code = 8'h00; m_rel = 1'b0; m_ext = 1'b0; m_ep = 1'b0; m_rp = 1'b0;
    rst_n = 1'b1;
    wait_cyc(20);
    send_byte(8'h75, 1'b0, -1);
    check_step("t6_75");
    chk("t6_scancode_live", scancode, 8'h75);

    chk("strobes_same_cycle", both_cnt[7:0], 8'h00);
    chk("strobe_longer_than_1", long_cnt[7:0], 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
PS/2 keyboard receiver that sits directly upstream of the pin-test keypad decoder. It deserialises device-to-host frames from the external PS/2 clock and data lines, folds the E0 (extended) and F0 (break) prefix bytes into flags, and delivers one complete scancode event per key action as a single-cycle strobe. It also reports malformed frames, so the downstream stage never sees a corrupted code.

Parameters:
FILTER_LEN, 8, number of consecutive equal synchronised ps2clk samples required to change the filtered clock level.
TIMEOUT_CYCLES, 50000, clk cycles with no filtered falling edge before a partial frame is discarded (about 1.8 ms at 28 MHz).

Ports:
clk  input  1  system clock; all logic runs on its rising edge.
rst_n  input  1  asynchronous reset, active low.
enable_rcv  input  1  1 = receive frames; 0 = hold FSM in IDLE and abort any frame in progress.
ps2clk_ext  input  1  raw PS/2 clock from the connector.
ps2data_ext  input  1  raw PS/2 data from the connector.
kb_interrupt  output  1  one-cycle strobe: scancode, released and extended are valid.
scancode  output  8  last accepted non-prefix byte.
released  output  1  1 if that byte was preceded by F0.
extended  output  1  1 if that byte was preceded by E0.
frame_err  output  1  one-cycle strobe on a parity or stop-bit error.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: kb_interrupt=0, scancode=8'h00, released=0, extended=0, frame_err=0. Internal state: FSM=IDLE, ext_pend=0, rel_pend=0, filtered clock=1, timeout counter=0. An assertion of rst_n mid-frame discards the frame immediately.
- Input conditioning: both lines pass through a 2-FF synchroniser.
  - The filtered clock goes to 0 only after FILTER_LEN consecutive 0 samples, and to 1 only after FILTER_LEN consecutive 1 samples.
  - A 1→0 transition of the filtered clock is a sample event. On that event, the synchronised data bit is captured.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur on sample events only.
  - IDLE: data=0 (start bit) → DATA with bitcnt=0. data=1 → stay in IDLE (noise, ignored silently).
  - DATA: shift in LSB-first. When bitcnt=7 → PARITY; otherwise increment bitcnt.
  - PARITY: capture the parity bit → STOP.
  - STOP: evaluate the frame, then → IDLE.
- Frame evaluation, in the STOP state:
  - The frame is valid when stop=1 AND (XOR of 8 data bits and the parity bit)=1 (odd parity).
  - Valid frame, byte=E0: set ext_pend. No strobe.
  - Valid frame, byte=F0: set rel_pend. No strobe.
  - Valid frame, any other byte (E1 included): scancode←byte, released←rel_pend, extended←ext_pend. Assert kb_interrupt for exactly one cycle, in the cycle after the stop-bit sample event. Clear both pending flags.
  - Invalid frame: assert frame_err for one cycle (same timing as kb_interrupt). Clear both pending flags. scancode, released and extended hold their values.
- Output hold: scancode, released and extended change only on a kb_interrupt cycle.
- Timeout:
  - The counter clears on every sample event and while in IDLE; it increments otherwise.
  - When the counter reaches TIMEOUT_CYCLES-1 outside IDLE: FSM→IDLE, frame discarded, pending flags cleared, no strobe.
  - If a sample event and the timeout coincide in the same cycle, the sample event wins.
- enable_rcv=0: FSM forced to IDLE, counter cleared, pending flags cleared, sample events ignored. Outputs hold; no strobes are generated.
- kb_interrupt and frame_err are never asserted in the same cycle. Each strobe lasts one cycle only, regardless of how fast the PS/2 clock runs.

Test Plan:
1. enable_rcv=1. Send frame 0x70 at a 40 µs PS/2 bit period: start 0, data bits 0,0,0,0,1,1,1,0, parity 0, stop 1 → exactly one kb_interrupt; scancode=70, released=0, extended=0; frame_err stays 0.
2. Send E0, F0, 5A → no strobe after E0 or F0; one strobe after 5A with scancode=5A, released=1, extended=1. Then send E0, 5A → strobe with released=0, extended=1.
3. Send 0x69 with parity 0 (correct parity is 1) → frame_err pulses once; no kb_interrupt; scancode stays at its previous value. A following F0, 69 → released=1, extended=0, confirming the error cleared no later prefix.
4. Stop a frame after 4 data bits, idle for more than TIMEOUT_CYCLES, then send a full 0x72 frame → no strobe from the partial frame; one strobe for 0x72, scancode=72.
5. Inject a 3-cycle low glitch on ps2clk_ext mid-frame, then complete 0x7A → glitch not counted; scancode=7A. Separately, deassert enable_rcv mid-frame → no strobe; the next full frame is accepted normally.
6. Assert rst_n low mid-frame, release it, send 0x75 → all outputs read reset values while in reset; afterwards exactly one strobe with scancode=75.
